// File: rtl/led_wave_gen.sv
// Multi-channel PWM LED pattern generator: phase accumulator, per-channel phase spread,
// sequential duty calculation into a shadow buffer committed glitch-free at PWM wrap.
module led_wave_gen #(
   parameter int NUM_LEDS        = 8,
   parameter int PWM_BITS        = 8,
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          mode_req,
   input  logic                mode_wr,
   input  logic [PWM_BITS-1:0] step,
   input  logic [PWM_BITS:0]   spread,
   output logic [NUM_LEDS-1:0] led,
   output logic                frame_tick,
   output logic                busy
);

   localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
   localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FRAMES_PER_STEP - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_LEDS - 1);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_TRI   = 2'd1,
      MODE_SAW   = 2'd2,
      MODE_SOLID = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [PWM_BITS-1:0] pwm_ctr_reg;
   logic [FC_W-1:0]     frame_cnt_reg;
   logic [PWM_BITS:0]   phase_reg;
   logic                frame_tick_reg;
   mode_t               active_mode_reg;
   mode_t               pending_mode_reg;
   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [PWM_BITS-1:0] shadow_duty_reg [NUM_LEDS];
   logic [PWM_BITS-1:0] active_duty_reg [NUM_LEDS];
   logic [NUM_LEDS-1:0] led_reg, led_next;

   logic                wrap;
   logic                calc_we;
   logic                pwm_mode;
   logic [PWM_BITS:0]   p_calc;
   logic [PWM_BITS-1:0] duty_calc;

   assign wrap     = enable && (pwm_ctr_reg == PWM_MAX);
   assign calc_we  = (state_reg == ST_CALC);
   assign pwm_mode = (active_mode_reg == MODE_TRI) || (active_mode_reg == MODE_SAW);

   // Counters, mode commit and phase accumulator; a pending mode change takes
   // precedence over the phase step on the same wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_ctr_reg      <= '0;
         frame_cnt_reg    <= '0;
         phase_reg        <= '0;
         frame_tick_reg   <= 1'b0;
         active_mode_reg  <= MODE_OFF;
         pending_mode_reg <= MODE_OFF;
      end else begin
         frame_tick_reg <= wrap;
         if (enable) begin
            pwm_ctr_reg <= pwm_ctr_reg + 1'b1;
         end
         if (mode_wr) begin
            pending_mode_reg <= mode_t'(mode_req);
         end
         if (wrap) begin
            if (pending_mode_reg != active_mode_reg) begin
               active_mode_reg <= pending_mode_reg;
               phase_reg       <= '0;
               frame_cnt_reg   <= '0;
            end else if (frame_cnt_reg == FC_LAST) begin
               frame_cnt_reg <= '0;
               phase_reg     <= phase_reg + {1'b0, step};
            end else begin
               frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      if (wrap) begin
         state_next = ST_CALC;
         idx_next   = '0;
      end else if (state_reg == ST_CALC) begin
         if (idx_reg == IDX_LAST) begin
            state_next = ST_DONE;
         end else begin
            idx_next = idx_reg + 1'b1;
         end
      end
   end

   // Channel phase wraps modulo 2**(PWM_BITS+1); the MSB selects the falling half of the triangle.
   always_comb begin
      p_calc    = phase_reg + (PWM_BITS + 1)'(idx_reg) * spread;
      duty_calc = '0;
      case (active_mode_reg)
         MODE_TRI: duty_calc = p_calc[PWM_BITS] ? ~p_calc[PWM_BITS-1:0] : p_calc[PWM_BITS-1:0];
         MODE_SAW: duty_calc = p_calc[PWM_BITS-1:0];
         default:  duty_calc = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            shadow_duty_reg[i] <= '0;
            active_duty_reg[i] <= '0;
         end
      end else begin
         if (wrap) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
               active_duty_reg[i] <= shadow_duty_reg[i];
            end
         end
         if (calc_we) begin
            shadow_duty_reg[idx_reg] <= duty_calc;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
         assign led_next[gi] = enable &&
                               ((active_mode_reg == MODE_SOLID) ||
                                (pwm_mode && (active_duty_reg[gi] > pwm_ctr_reg)));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         led_reg <= '0;
      end else begin
         led_reg <= led_next;
      end
   end

   assign led        = led_reg;
   assign frame_tick = frame_tick_reg;
   assign busy       = (state_reg == ST_CALC);

endmodule

// File: tb/tb_led_wave_gen.sv
// Directed bench for led_wave_gen: per-period LED high counts checked against a queue of
// expected counts, plus busy/frame_tick timing, enable gaps and reset behaviour.
module tb_led_wave_gen;

   localparam int NUM_LEDS = 8;
   localparam int PWM_BITS = 8;
   localparam int PERIOD   = 256;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic [1:0]          mode_req;
   logic                mode_wr;
   logic [PWM_BITS-1:0] step;
   logic [PWM_BITS:0]   spread;
   logic [NUM_LEDS-1:0] led;
   logic                frame_tick;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   led_wave_gen #(
      .NUM_LEDS(NUM_LEDS),
      .PWM_BITS(PWM_BITS),
      .FRAMES_PER_STEP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .mode_req(mode_req),
      .mode_wr(mode_wr),
      .step(step),
      .spread(spread),
      .led(led),
      .frame_tick(frame_tick),
      .busy(busy)
   );

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Expected high count for channel i in one period: base + mult*i
   task automatic push_period(input int base, input int mult);
      for (int i = 0; i < NUM_LEDS; i++) begin
         exp_q.push_back(base + mult * i);
      end
   endtask

   // Starts at the negedge where pwm_ctr==0 and ends on the next frame_tick negedge.
   task automatic run_period(input string name, input int wr_at, input logic [1:0] wr_mode,
                             input logic [PWM_BITS-1:0] new_step, input logic [PWM_BITS:0] new_spread,
                             input int gap_at, input int gap_len, input int exp_busy);
      int len;
      int cnt[NUM_LEDS];
      int busy_cnt;
      int tick_cnt;
      int tick_pos;
      int gap_bad;
      int exp_v;
      len      = PERIOD + gap_len;
      busy_cnt = 0;
      tick_cnt = 0;
      tick_pos = -1;
      gap_bad  = 0;
      for (int i = 0; i < NUM_LEDS; i++) cnt[i] = 0;
      for (int j = 0; j < len; j++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_LEDS; i++) if (led[i]) cnt[i]++;
         if (busy) busy_cnt++;
         if (frame_tick) begin
            tick_cnt++;
            tick_pos = j;
         end
         if (gap_len > 0 && j > gap_at && j <= gap_at + gap_len && led != '0) gap_bad++;
         mode_wr = 1'b0;
         if (j == wr_at) begin
            mode_wr  = 1'b1;
            mode_req = wr_mode;
            step     = new_step;
            spread   = new_spread;
         end
         if (gap_len > 0 && j == gap_at) enable = 1'b0;
         if (gap_len > 0 && j == gap_at + gap_len) enable = 1'b1;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
         exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         check($sformatf("%s led[%0d] high count", name, i), cnt[i], exp_v);
      end
      check($sformatf("%s busy cycles", name), busy_cnt, exp_busy);
      check($sformatf("%s tick count*1000+pos", name), tick_cnt * 1000 + tick_pos, 1000 + len - 1);
      if (gap_len > 0) check($sformatf("%s led during gap", name), gap_bad, 0);
      $display("period %s: led high counts %0d %0d %0d %0d %0d %0d %0d %0d busy=%0d",
               name, cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5], cnt[6], cnt[7], busy_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      mode_wr  = 1'b0;
      mode_req = 2'd0;
      step     = '0;
      spread   = 9'd32;
      repeat (3) @(negedge clk);
      check("reset led", int'(led), 0);
      check("reset busy", int'(busy), 0);
      check("reset frame_tick", int'(frame_tick), 0);
      rst    = 1'b0;
      enable = 1'b1;

      // OFF after reset: dark for 8 periods
      for (int k = 0; k < 8; k++) begin
         push_period(0, 0);
         run_period($sformatf("off%0d", k), -1, 2'd0, 8'd0, 9'd32, -1, 0, (k == 0) ? 1 : 8);
      end

      // SAWTOOTH, step 0, spread 32: two dark periods then 32*i
      push_period(0, 0);
      push_period(0, 0);
      push_period(0, 32);
      push_period(0, 32);
      run_period("saw_a", 10, 2'd2, 8'd0, 9'd32, -1, 0, 8);
      run_period("saw_b", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);
      run_period("saw_c", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);
      // Request TRIANGLE, step 64, spread 0 late in this period
      run_period("saw_d", 10, 2'd1, 8'd64, 9'd0, -1, 0, 8);

      // TRIANGLE with 4 frames per step: stale sawtooth, then 0,64,128,192,255 held 4 periods each, then 191
      push_period(0, 32);
      for (int k = 0; k < 4; k++) push_period(0, 0);
      for (int k = 0; k < 4; k++) push_period(64, 0);
      for (int k = 0; k < 4; k++) push_period(128, 0);
      for (int k = 0; k < 4; k++) push_period(192, 0);
      for (int k = 0; k < 4; k++) push_period(255, 0);
      push_period(191, 0);
      for (int k = 0; k < 22; k++) begin
         run_period($sformatf("tri%0d", k), -1, 2'd0, 8'd64, 9'd0, -1, 0, 8);
      end

      // SOLID requested mid-period at pwm_ctr=100
      push_period(191, 0);
      push_period(256, 0);
      run_period("solid_req", 99, 2'd3, 8'd64, 9'd0, -1, 0, 8);
      run_period("solid_on", -1, 2'd0, 8'd64, 9'd0, -1, 0, 8);

      // SAWTOOTH requested exactly on the wrap: applied one period later
      push_period(256, 0);
      push_period(256, 0);
      push_period(0, 0);
      push_period(0, 32);
      run_period("wr_on_wrap", 254, 2'd2, 8'd0, 9'd32, -1, 0, 8);
      run_period("still_solid", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);
      run_period("saw_stale", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);
      run_period("saw_again", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);

      // Enable dropped at pwm_ctr=50 for 20 cycles
      push_period(0, 32);
      run_period("enable_gap", -1, 2'd0, 8'd0, 9'd32, 49, 20, 8);

      // Reset while calculating channel 3
      repeat (3) @(negedge clk);
      check("busy before mid-calc reset", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid-calc reset led", int'(led), 0);
      check("mid-calc reset busy", int'(busy), 0);
      check("mid-calc reset frame_tick", int'(frame_tick), 0);
      rst = 1'b0;
      $display("reset applied during duty calculation");

      push_period(0, 0);
      push_period(0, 0);
      run_period("post_rst0", -1, 2'd0, 8'd0, 9'd32, -1, 0, 1);
      run_period("post_rst1", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);
      push_period(0, 0);
      push_period(0, 0);
      push_period(0, 32);
      run_period("resaw_a", 10, 2'd2, 8'd0, 9'd32, -1, 0, 8);
      run_period("resaw_b", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);
      run_period("resaw_c", -1, 2'd0, 8'd0, 9'd32, -1, 0, 8);

      check("scoreboard drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_wave_gen.md
Name: led_wave_gen

Overview:
Multi-channel PWM LED pattern generator with a phase accumulator, per-channel phase spread and run-time selectable modes (off, triangle, sawtooth, solid). Per-channel duties are computed sequentially, one channel per clock, into a shadow buffer. The buffer is committed at PWM period boundaries, so duty updates never glitch. Sits between the board LED pins and control logic that writes mode/speed settings.

Parameters:
NUM_LEDS, 8, number of LED channels; must satisfy NUM_LEDS+2 <= 2**PWM_BITS
PWM_BITS, 8, PWM resolution; PWM period = 2**PWM_BITS enabled cycles
FRAMES_PER_STEP, 4, PWM periods between phase-accumulator advances (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
enable  input  1  run PWM; 0 freezes counters and blanks LEDs
mode_req  input  2  requested mode: 0 OFF, 1 TRIANGLE, 2 SAWTOOTH, 3 SOLID
mode_wr  input  1  one-cycle strobe capturing mode_req into pending register
step  input  PWM_BITS  phase increment per phase advance
spread  input  PWM_BITS+1  phase offset between adjacent channels
led  output  NUM_LEDS  registered LED drive
frame_tick  output  1  one-cycle pulse on every PWM wrap
busy  output  1  high while duty calculation is in progress

Behaviour:
- Reset: pwm_ctr, frame_cnt, phase, shadow/active duties, led, frame_tick and busy are all 0; active and pending mode = OFF; FSM = IDLE.
- pwm_ctr (PWM_BITS): +1 per cycle when enable; wraps max->0. Wrap event W = enable && pwm_ctr==max. frame_tick is registered and equals W delayed by 1 cycle.
- frame_cnt counts W from 0 to FRAMES_PER_STEP-1. On W with frame_cnt at terminal: phase <= phase+step, mod 2**(PWM_BITS+1), step zero-extended.
- Mode: mode_wr loads pending_mode. On W, if pending != active: active <= pending, phase <= 0, frame_cnt <= 0, with no step applied that W. A mode_wr coinciding with W is captured but committed only at the following W, because the commit uses the old pending value.
- Calc FSM: IDLE/DONE, then CALC.
  - On W: active_duty[] <= shadow_duty[] (all channels at once); FSM -> CALC, idx=0.
  - In CALC: one channel per cycle, p = phase + idx*spread, truncated to PWM_BITS+1 bits, using the phase value already updated by that W.
  - Duty by mode: TRIANGLE = p[MSB] ? ~p[PWM_BITS-1:0] : p[PWM_BITS-1:0]; SAWTOOTH = p[PWM_BITS-1:0]; OFF/SOLID = 0.
  - After idx = NUM_LEDS-1 -> DONE. busy=1 exactly in CALC (NUM_LEDS cycles).
  - Latency: a phase/mode committed at W reaches LEDs at the next W, i.e. one PWM period later.
- led[i], registered each cycle:
  - enable=0 -> 0.
  - OFF -> 0.
  - SOLID -> 1.
  - TRIANGLE/SAWTOOTH -> active_duty[i] > pwm_ctr, unsigned. Duty 0 is never on; duty 2**PWM_BITS-1 is off only at the max count.
- enable=0: pwm_ctr, frame_cnt and phase hold; an in-progress CALC still completes; operation resumes from the held counter value.
- Reset mid-CALC or mid-period: returns to the reset state next cycle with no partial commit.

Test Plan:
- Reset, enable=1, no mode_wr, 2048 cycles -> led=0 throughout; frame_tick every 256 cycles; busy high 8 cycles after each tick.
- SAWTOOTH, step=0, spread=32 (defaults) -> from third period on, led[i] high exactly 32*i cycles per 256 (led[0] never).
- TRIANGLE, FRAMES_PER_STEP=1, step=64, spread=0 -> led[0] per-period high counts 0,0,64,128,192,255,191,127,63,0 (one-period lag, fold at 256).
- mode_wr=SOLID at pwm_ctr=100 -> led unchanged until wrap; all ones from cycle after the W; mode_wr exactly on W -> applied one period later.
- Deassert enable at pwm_ctr=50 for 20 cycles -> led=0 next cycle, pwm_ctr stays 50, resumes at 51; no frame_tick during gap.
- rst during CALC (idx=3) -> next cycle led=0, busy=0, mode OFF; after release SAWTOOTH needs a fresh mode_wr.
